// File: rtl/amns_pkg.sv
// amns_pkg: shared word/slice types and feeder state encoding for the AMNS operand feeder
package amns_pkg;
    localparam int AMNS_WORD_WIDTH = 17;
    localparam int AMNS_N = 5;
    typedef logic [AMNS_WORD_WIDTH-1:0] word_t;
    typedef word_t [AMNS_N-1:0] slice_t;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;
endpackage

// File: rtl/amns_operand_bank.sv
// amns_operand_bank: S x N word store with serial write counter and saturating slice read pointer
module amns_operand_bank
    import amns_pkg::*;
#(
    parameter int WORD_WIDTH = 17,
    parameter int N = 5,
    parameter int S = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    wr_i,
    input  logic [WORD_WIDTH-1:0]   wr_data_i,
    input  logic                    shift_i,
    input  logic                    clr_i,
    input  logic                    oe_i,
    output logic [N*WORD_WIDTH-1:0] din_o,
    output logic                    full_o,
    output logic                    fill_o,
    output logic                    ovr_o
);
    localparam int CW = $clog2(N*S+1);
    localparam int PW = $clog2(S+1);
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = (S > 1) ? $clog2(S) : 1;
    logic [WORD_WIDTH-1:0] r_mem [S][N];
    logic [CW-1:0] r_cnt;
    logic [LW-1:0] r_lane;
    logic [IW-1:0] r_slice;
    logic [PW-1:0] r_ptr;
    logic w_full, w_exh, w_wr, w_shift;
    logic [IW-1:0] w_rd_idx;
    assign w_full   = r_cnt == CW'(N*S);
    assign w_exh    = r_ptr == PW'(S);
    assign w_wr     = wr_i && !w_full;
    assign w_shift  = shift_i && !w_exh;
    assign w_rd_idx = r_ptr[IW-1:0];
    assign full_o   = w_full;
    // fill_o anticipates the counter so the FSM can leave IDLE right after the last write
    assign fill_o   = w_full || (w_wr && r_cnt == CW'(N*S-1));
    assign ovr_o    = (wr_i && w_full) || (shift_i && w_exh);
    always_ff @(posedge clock_i) begin
        if (!reset_i || clr_i) begin
            r_cnt   <= '0;
            r_lane  <= '0;
            r_slice <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_wr) begin
                r_cnt   <= r_cnt + 1'b1;
                r_lane  <= (r_lane == LW'(N-1)) ? '0 : r_lane + 1'b1;
                r_slice <= (r_lane == LW'(N-1)) ? r_slice + 1'b1 : r_slice;
            end
            if (w_shift) r_ptr <= r_ptr + 1'b1;
        end
    end
    always_ff @(posedge clock_i) begin
        if (w_wr) r_mem[r_slice][r_lane] <= wr_data_i;
    end
    for (genvar g = 0; g < N; g++) begin : g_lane
        assign din_o[g*WORD_WIDTH +: WORD_WIDTH] = (oe_i && !w_exh) ? r_mem[w_rd_idx][g] : '0;
    end
endmodule

// File: rtl/amns_operand_feeder.sv
// amns_operand_feeder: loads B/M operands serially and feeds them slice by slice to the AMNS multiplier
module amns_operand_feeder
    import amns_pkg::*;
#(
    parameter int WORD_WIDTH = 17,
    parameter int N = 5,
    parameter int S = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    input  logic                    wr_sel_i,
    input  logic [WORD_WIDTH-1:0]   wr_data_i,
    input  logic                    run_i,
    output logic                    mult_start_o,
    output logic [N*WORD_WIDTH-1:0] B_din_o,
    output logic [N*WORD_WIDTH-1:0] M_din_o,
    input  logic                    B_shift_i,
    input  logic                    M_shift_i,
    input  logic                    mult_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);
    feeder_state_t r_state, w_next;
    logic r_err, r_start;
    logic w_run, w_acc, w_oe, w_clr;
    logic w_b_shift, w_m_shift;
    logic w_b_full, w_m_full, w_b_fill, w_m_fill, w_b_ovr, w_m_ovr;
    assign w_run     = r_state == RUN;
    assign w_acc     = wr_valid_i && r_state == IDLE;
    assign w_oe      = w_run && reset_i;
    assign w_clr     = r_state == DONE;
    // a completion in the same cycle as a shift takes priority
    assign w_b_shift = B_shift_i && w_run && !mult_done_i;
    assign w_m_shift = M_shift_i && w_run && !mult_done_i;
    amns_operand_bank #(.WORD_WIDTH(WORD_WIDTH), .N(N), .S(S)) u_bank_b (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_i      (w_acc && !wr_sel_i),
        .wr_data_i (wr_data_i),
        .shift_i   (w_b_shift),
        .clr_i     (w_clr),
        .oe_i      (w_oe),
        .din_o     (B_din_o),
        .full_o    (w_b_full),
        .fill_o    (w_b_fill),
        .ovr_o     (w_b_ovr)
    );
    amns_operand_bank #(.WORD_WIDTH(WORD_WIDTH), .N(N), .S(S)) u_bank_m (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .wr_i      (w_acc && wr_sel_i),
        .wr_data_i (wr_data_i),
        .shift_i   (w_m_shift),
        .clr_i     (w_clr),
        .oe_i      (w_oe),
        .din_o     (M_din_o),
        .full_o    (w_m_full),
        .fill_o    (w_m_fill),
        .ovr_o     (w_m_ovr)
    );
    always_comb begin
        w_next = (r_state == IDLE)  ? ((w_b_fill && w_m_fill) ? READY : IDLE) :
                 (r_state == READY) ? (run_i ? RUN : READY) :
                 (r_state == RUN)   ? (mult_done_i ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= r_err || w_b_ovr || w_m_ovr;
            r_start <= r_state == READY && run_i;
        end
    end
    // every output is forced low while reset is held
    assign wr_ready_o   = reset_i && r_state == IDLE;
    assign mult_start_o = reset_i && r_start;
    assign busy_o       = reset_i && w_run;
    assign done_o       = reset_i && r_state == DONE;
    assign err_o        = reset_i && r_err;
    logic w_unused;
    assign w_unused = w_b_full ^ w_m_full;
endmodule

// File: tb/tb_amns_operand_feeder.sv
// tb_amns_operand_feeder: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_amns_operand_feeder;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic        wr_sel_i = 1'b0;
    logic [16:0] wr_data_i = '0;
    logic        run_i = 1'b0;
    logic        B_shift_i = 1'b0;
    logic        M_shift_i = 1'b0;
    logic        mult_done_i = 1'b0;
    logic        wr_ready_o, mult_start_o, busy_o, done_o, err_o;
    logic [84:0] B_din_o, M_din_o;
    always #5 clock_i = ~clock_i;
    amns_operand_feeder #(.WORD_WIDTH(17), .N(5), .S(4)) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_sel_i     (wr_sel_i),
        .wr_data_i    (wr_data_i),
        .run_i        (run_i),
        .mult_start_o (mult_start_o),
        .B_din_o      (B_din_o),
        .M_din_o      (M_din_o),
        .B_shift_i    (B_shift_i),
        .M_shift_i    (M_shift_i),
        .mult_done_i  (mult_done_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );
    int n_tests = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // model: phase 0 loading, 1 loaded, 2 running, 3 finishing
    int ph, bc, mc, bp, mp;
    bit merr, mfirst;
    logic [16:0] bq [20];
    logic [16:0] mq [20];
    logic [84:0] eb, em;
    task automatic model_step();
        if (!reset_i) begin
            ph = 0; bc = 0; mc = 0; bp = 0; mp = 0; merr = 0; mfirst = 0;
        end else begin
            mfirst = (ph == 1 && run_i);
            if (ph == 0) begin
                if (wr_valid_i && wr_sel_i) begin
                    if (mc < 20) begin mq[mc] = wr_data_i; mc++; end else merr = 1;
                end
                if (wr_valid_i && !wr_sel_i) begin
                    if (bc < 20) begin bq[bc] = wr_data_i; bc++; end else merr = 1;
                end
                if (bc == 20 && mc == 20) ph = 1;
            end else if (ph == 1) begin
                if (run_i) ph = 2;
            end else if (ph == 2) begin
                if (mult_done_i) ph = 3;
                else begin
                    if (B_shift_i) begin if (bp < 4) bp++; else merr = 1; end
                    if (M_shift_i) begin if (mp < 4) mp++; else merr = 1; end
                end
            end else begin
                bc = 0; mc = 0; bp = 0; mp = 0; ph = 0;
            end
        end
    endtask
    always @(posedge clock_i) model_step();
    always @(negedge clock_i) begin
        if (cmp_en) begin
            eb = '0;
            em = '0;
            if (reset_i && ph == 2) begin
                for (int i = 0; i < 5; i++) begin
                    if (bp < 4) eb[i*17 +: 17] = bq[bp*5+i];
                    if (mp < 4) em[i*17 +: 17] = mq[mp*5+i];
                end
            end
            chk("m_wr_ready", wr_ready_o, reset_i && ph == 0);
            chk("m_start", mult_start_o, reset_i && mfirst);
            chk("m_busy", busy_o, reset_i && ph == 2);
            chk("m_done", done_o, reset_i && ph == 3);
            chk("m_err", err_o, reset_i && merr);
            chk("m_B_din", B_din_o, eb);
            chk("m_M_din", M_din_o, em);
        end
    end
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask
    task automatic wr(input bit sel, input logic [16:0] d);
        wr_valid_i = 1; wr_sel_i = sel; wr_data_i = d;
        tick();
        wr_valid_i = 0;
    endtask
    task automatic shift(input bit b, input bit m);
        B_shift_i = b; M_shift_i = m;
        tick();
        B_shift_i = 0; M_shift_i = 0;
    endtask
    task automatic lane(input string nm, input logic [84:0] bus, input int i, input logic [16:0] e);
        chk(nm, bus[i*17 +: 17], e);
    endtask
    initial begin
        reset_i = 0;
        tick();
        cmp_en = 1;
        chk("rst_ready", wr_ready_o, 0);
        reset_i = 1;
        tick();
        chk("rel_ready", wr_ready_o, 1);
        for (int k = 0; k < 19; k++) begin
            wr(0, 17'(k));
            wr(1, 17'(32'h100 + k));
        end
        wr(1, 17'h113);
        run_i = 1; tick(); run_i = 0;
        chk("idle_run_start", mult_start_o, 0);
        chk("idle_run_ready", wr_ready_o, 1);
        tick();
        chk("idle_run_busy", busy_o, 0);
        wr(0, 17'd19);
        chk("ready_wr_ready", wr_ready_o, 0);
        run_i = 1; tick(); run_i = 0;
        chk("start_pulse", mult_start_o, 1);
        for (int i = 0; i < 5; i++) begin
            lane("b_slice0", B_din_o, i, 17'(i));
            lane("m_slice0", M_din_o, i, 17'(32'h100 + i));
        end
        tick();
        chk("start_once", mult_start_o, 0);
        shift(1, 1);
        shift(1, 0);
        shift(1, 0);
        for (int i = 0; i < 5; i++) begin
            lane("b_slice3", B_din_o, i, 17'(15 + i));
            lane("m_slice1", M_din_o, i, 17'(32'h105 + i));
        end
        shift(1, 0);
        chk("b_exhausted", B_din_o, 85'd0);
        chk("err_after4", err_o, 0);
        shift(1, 0);
        chk("err_after5", err_o, 1);
        mult_done_i = 1; B_shift_i = 1; tick(); mult_done_i = 0; B_shift_i = 0;
        chk("done_pulse", done_o, 1);
        tick();
        chk("done_once", done_o, 0);
        chk("idle_ready", wr_ready_o, 1);
        chk("err_sticky", err_o, 1);
        reset_i = 0; tick();
        chk("rst_err", err_o, 0);
        reset_i = 1; tick();
        for (int k = 0; k < 20; k++) wr(0, 17'(32'h50 + k));
        for (int k = 0; k < 10; k++) wr(1, 17'(32'h100 + k));
        wr(0, 17'h1ffff);
        chk("ovr_err", err_o, 1);
        for (int k = 10; k < 20; k++) wr(1, 17'(32'h100 + k));
        run_i = 1; tick(); run_i = 0;
        lane("ovr_b_lane0", B_din_o, 0, 17'h50);
        lane("ovr_m_lane0", M_din_o, 0, 17'h100);
        shift(1, 1);
        shift(1, 1);
        reset_i = 0; tick();
        chk("midrun_busy", busy_o, 0);
        chk("midrun_B", B_din_o, 85'd0);
        chk("midrun_M", M_din_o, 85'd0);
        chk("midrun_err", err_o, 0);
        chk("midrun_ready", wr_ready_o, 0);
        reset_i = 1; tick();
        chk("post_rst_ready", wr_ready_o, 1);
        chk("post_rst_err", err_o, 0);
        for (int k = 0; k < 20; k++) begin
            wr(0, 17'(k));
            wr(1, 17'(32'h100 + k));
        end
        run_i = 1; tick(); run_i = 0;
        chk("reload_start", mult_start_o, 1);
        for (int i = 0; i < 5; i++) lane("reload_b", B_din_o, i, 17'(i));
        lane("reload_m", M_din_o, 0, 17'h100);
        for (int j = 0; j < 4; j++) shift(1, 0);
        chk("exh_zero", B_din_o, 85'd0);
        mult_done_i = 1; B_shift_i = 1; tick(); mult_done_i = 0; B_shift_i = 0;
        chk("done_wins_err", err_o, 0);
        chk("done_wins_pulse", done_o, 1);
        tick();
        chk("final_ready", wr_ready_o, 1);
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
